// File: rtl/gerador_ov7670.sv
// gerador_ov7670
// ----------------------------------------------------------------------------
// OV7670 camera emulator. Emits one frame per rising edge of `iniciar`, with
// the sensor's VSYNC/HREF/PCLK/D framing, RGB565 high byte first.
//
// Optional feature: define GERADOR_BARRAS_EN to emit 8 vertical colour bars.
// Without it each pixel is {line[7:0], column[7:0]}.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   iniciar    in   start request (level; its rising edge is detected here)
//   VSYNC      out  frame sync, active-high
//   HREF       out  line valid
//   PCLK       out  pixel clock, period 2*PCLK_DIV system clocks
//   D          out  pixel byte, 0 outside active lines
//   pronto     out  one-clock pulse at end of frame
//   db_estado  out  current state code (0 OCIOSO .. 6 FIM)
//
// Handshake: there is no ready/valid pair here. A consumer samples D on
// every PCLK rising edge while HREF=1; D and HREF only move on the clock in
// which PCLK falls ("tick"), so both are stable at each rising edge.
// ----------------------------------------------------------------------------
module gerador_ov7670 #(
    parameter int LINES    = 140,
    parameter int COLUMNS  = 320,
    parameter int S_LINE   = 8,
    parameter int S_COLUMN = 9,
    parameter int PCLK_DIV = 2,
    parameter int V_PULSE  = 3,
    parameter int V_BACK   = 17,
    parameter int H_BLANK  = 144,
    parameter int V_FRONT  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       VSYNC,
    output logic       HREF,
    output logic       PCLK,
    output logic [7:0] D,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        VSYNC_ATIVO = 4'd1,
        PRE         = 4'd2,
        LINHA       = 4'd3,
        HBLANK      = 4'd4,
        POS         = 4'd5,
        FIM         = 4'd6
    } estado_t;

    localparam logic [15:0]         DIV_FIM     = 16'(PCLK_DIV - 1);
    localparam logic [15:0]         V_PULSE_FIM = 16'(V_PULSE - 1);
    localparam logic [15:0]         V_BACK_FIM  = 16'(V_BACK - 1);
    localparam logic [15:0]         H_BLANK_FIM = 16'(H_BLANK - 1);
    localparam logic [15:0]         V_FRONT_FIM = 16'(V_FRONT - 1);
    localparam logic [S_COLUMN-1:0] COL_FIM     = S_COLUMN'(COLUMNS - 1);
    localparam logic [S_LINE-1:0]   LIN_FIM     = S_LINE'(LINES - 1);

    estado_t             estado;
    logic [15:0]         div_cnt;
    logic [15:0]         periodos;
    logic [S_LINE-1:0]   linha;
    logic [S_COLUMN-1:0] coluna;
    logic                fase;        // 0: high byte on D, 1: low byte on D
    logic                iniciar_ant;
    logic                pendente;
    logic                subida;
    logic                tick;

    assign subida    = iniciar & ~iniciar_ant;
    // Last system clock of PCLK's high half: PCLK falls on this edge.
    assign tick      = PCLK & (div_cnt == DIV_FIM);
    assign db_estado = estado;

    function automatic logic [15:0] pixel(input logic [S_LINE-1:0] l,
                                          input logic [S_COLUMN-1:0] c);
`ifdef GERADOR_BARRAS_EN
        logic [2:0] barra;
        barra = 3'((32'(c) * 32'd8) / 32'(COLUMNS));
        case (barra)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        return {8'(l), 8'(c)};
`endif
    endfunction

    function automatic logic [7:0] byte_alto(input logic [S_LINE-1:0] l,
                                             input logic [S_COLUMN-1:0] c);
        return 8'(pixel(l, c) >> 8);
    endfunction

    function automatic logic [7:0] byte_baixo(input logic [S_LINE-1:0] l,
                                              input logic [S_COLUMN-1:0] c);
        return 8'(pixel(l, c));
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= '0;
            PCLK        <= 1'b0;
            estado      <= OCIOSO;
            VSYNC       <= 1'b0;
            HREF        <= 1'b0;
            D           <= 8'h00;
            pronto      <= 1'b0;
            linha       <= '0;
            coluna      <= '0;
            fase        <= 1'b0;
            periodos    <= '0;
            pendente    <= 1'b0;
            // Absorb any level present during reset so it is not seen as
            // an edge once reset releases.
            iniciar_ant <= iniciar;
        end else begin
            iniciar_ant <= iniciar;

            if (div_cnt == DIV_FIM) begin
                div_cnt <= '0;
                PCLK    <= ~PCLK;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end

            // Start requests are only remembered while idle.
            if (estado == OCIOSO) begin
                if (subida) pendente <= 1'b1;
            end else begin
                pendente <= 1'b0;
            end

            if (estado == FIM) begin
                // pronto lasts one system clock, not one PCLK period.
                pronto   <= 1'b0;
                estado   <= OCIOSO;
                periodos <= '0;
            end else if (tick) begin
                periodos <= periodos + 16'd1;
                case (estado)
                    OCIOSO: begin
                        // An edge sampled on the tick itself starts at once.
                        if (pendente | subida) begin
                            estado   <= VSYNC_ATIVO;
                            VSYNC    <= 1'b1;
                            pendente <= 1'b0;
                            linha    <= '0;
                            coluna   <= '0;
                            fase     <= 1'b0;
                            periodos <= '0;
                        end
                    end
                    VSYNC_ATIVO: begin
                        if (periodos == V_PULSE_FIM) begin
                            estado   <= PRE;
                            VSYNC    <= 1'b0;
                            periodos <= '0;
                        end
                    end
                    PRE: begin
                        if (periodos == V_BACK_FIM) begin
                            estado   <= LINHA;
                            HREF     <= 1'b1;
                            coluna   <= '0;
                            fase     <= 1'b0;
                            D        <= byte_alto(linha, '0);
                            periodos <= '0;
                        end
                    end
                    LINHA: begin
                        if (!fase) begin
                            fase <= 1'b1;
                            D    <= byte_baixo(linha, coluna);
                        end else if (coluna == COL_FIM) begin
                            estado   <= HBLANK;
                            HREF     <= 1'b0;
                            D        <= 8'h00;
                            periodos <= '0;
                        end else begin
                            coluna <= coluna + 1'b1;
                            fase   <= 1'b0;
                            D      <= byte_alto(linha, coluna + 1'b1);
                        end
                    end
                    HBLANK: begin
                        if (periodos == H_BLANK_FIM) begin
                            periodos <= '0;
                            if (linha == LIN_FIM) begin
                                estado <= POS;
                            end else begin
                                estado <= LINHA;
                                linha  <= linha + 1'b1;
                                HREF   <= 1'b1;
                                coluna <= '0;
                                fase   <= 1'b0;
                                D      <= byte_alto(linha + 1'b1, '0);
                            end
                        end
                    end
                    POS: begin
                        if (periodos == V_FRONT_FIM) begin
                            estado   <= FIM;
                            pronto   <= 1'b1;
                            periodos <= '0;
                        end
                    end
                    default: begin
                        estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gerador_ov7670.sv
// tb_gerador_ov7670
// ----------------------------------------------------------------------------
// Two emulators share clock and reset: instance 0 (COLUMNS=4, PCLK_DIV=1) and
// instance 1 (COLUMNS=8, PCLK_DIV=3). A mux selects which one the frame
// monitor watches. Expected bytes and timings are computed from the framing
// rules with plain arithmetic; captured bytes are compared against exp_q.
// ----------------------------------------------------------------------------
module tb_gerador_ov7670;

    localparam int LINES   = 2;
    localparam int V_PULSE = 1;
    localparam int V_BACK  = 2;
    localparam int H_BLANK = 3;
    localparam int V_FRONT = 2;
    localparam int COLS0   = 4;
    localparam int DIV0    = 1;
    localparam int COLS1   = 8;
    localparam int DIV1    = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] ini;

    logic       vsync0, href0, pclk0, pronto0;
    logic [7:0] d0;
    logic [3:0] est0;
    logic       vsync1, href1, pclk1, pronto1;
    logic [7:0] d1;
    logic [3:0] est1;

    int         sel;
    logic       m_vsync, m_href, m_pclk, m_pronto;
    logic [7:0] m_d;
    logic [3:0] m_estado;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    gerador_ov7670 #(
        .LINES(LINES), .COLUMNS(COLS0), .S_LINE(8), .S_COLUMN(9),
        .PCLK_DIV(DIV0), .V_PULSE(V_PULSE), .V_BACK(V_BACK),
        .H_BLANK(H_BLANK), .V_FRONT(V_FRONT)
    ) dut0 (
        .clock(clock), .reset(reset), .iniciar(ini[0]),
        .VSYNC(vsync0), .HREF(href0), .PCLK(pclk0), .D(d0),
        .pronto(pronto0), .db_estado(est0)
    );

    gerador_ov7670 #(
        .LINES(LINES), .COLUMNS(COLS1), .S_LINE(8), .S_COLUMN(9),
        .PCLK_DIV(DIV1), .V_PULSE(V_PULSE), .V_BACK(V_BACK),
        .H_BLANK(H_BLANK), .V_FRONT(V_FRONT)
    ) dut1 (
        .clock(clock), .reset(reset), .iniciar(ini[1]),
        .VSYNC(vsync1), .HREF(href1), .PCLK(pclk1), .D(d1),
        .pronto(pronto1), .db_estado(est1)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always_comb begin
        m_vsync  = vsync0;
        m_href   = href0;
        m_pclk   = pclk0;
        m_pronto = pronto0;
        m_d      = d0;
        m_estado = est0;
        if (sel == 1) begin
            m_vsync  = vsync1;
            m_href   = href1;
            m_pclk   = pclk1;
            m_pronto = pronto1;
            m_d      = d1;
            m_estado = est1;
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_pixel(input int line, input int col,
                                              input int cols);
`ifdef GERADOR_BARRAS_EN
        logic [15:0] bars[8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        return bars[(col * 8) / cols];
`else
        return 16'(((line % 256) * 256) + (col % 256));
`endif
    endfunction

    task automatic build_expected(input int cols);
        logic [15:0] px;
        exp_q.delete();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < cols; c++) begin
                px = ref_pixel(l, c, cols);
                exp_q.push_back(px[15:8]);
                exp_q.push_back(px[7:0]);
            end
        end
    endtask

    // ---------------- driver + monitor ----------------
    // Starts one frame on instance s and checks it end to end.
    // hold: keep iniciar high afterwards; toggle: wiggle iniciar in LINHA.
    task automatic run_frame(input int s, input bit hold, input bit toggle);
        int cols, div, lat, clk_cnt, vs_high, first_href, lines;
        int href_run, unstable, idle_bad, tog_left, frame_clks;
        logic       p_pclk, p_href;
        logic [7:0] p_d, g;

        cols = (s == 1) ? COLS1 : COLS0;
        div  = (s == 1) ? DIV1 : DIV0;
        sel  = s;
        build_expected(cols);
        got_q.delete();

        repeat ($urandom_range(0, 2 * div + 2)) @(negedge clock);
        ini[s] = 1'b1;
        lat = 0;
        while (!m_vsync && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check_eq($sformatf("start_latency_dut%0d", s),
                 32'((lat >= 1) && (lat <= 2 * div + 1)), 32'd1);
        if (!m_vsync) return;
        if (!hold) ini[s] = 1'b0;

        tog_left   = toggle ? 2 * int'($urandom_range(1, 3)) : 0;
        clk_cnt    = 0;
        vs_high    = 1;
        first_href = -1;
        lines      = 0;
        href_run   = 0;
        unstable   = 0;
        p_pclk     = m_pclk;
        p_href     = m_href;
        p_d        = m_d;
        while (!m_pronto && clk_cnt < 2000) begin
            @(negedge clock);
            clk_cnt++;
            if (m_vsync) vs_high++;
            if (m_pclk && !p_pclk && m_href) begin
                got_q.push_back(m_d);
                href_run++;
                if (m_d !== p_d || m_href !== p_href) unstable++;
            end
            if (m_href && !p_href && first_href < 0) first_href = clk_cnt;
            if (!m_href && p_href) begin
                check_eq($sformatf("href_len_dut%0d", s), href_run, 2 * cols);
                lines++;
                href_run = 0;
            end
            if (tog_left > 0 && m_estado == 4'd3) begin
                ini[s] = ~ini[s];
                tog_left--;
            end
            p_pclk = m_pclk;
            p_href = m_href;
            p_d    = m_d;
        end

        frame_clks = (V_PULSE + V_BACK + LINES * (2 * cols + H_BLANK) + V_FRONT)
                     * 2 * div;
        check_eq("pronto_seen", 32'(m_pronto), 32'd1);
        check_eq($sformatf("frame_clocks_dut%0d", s), clk_cnt, frame_clks);
        check_eq("vsync_width", vs_high, V_PULSE * 2 * div);
        check_eq("first_href", first_href, (V_PULSE + V_BACK) * 2 * div);
        check_eq("line_count", lines, LINES);
        check_eq("stable_at_pclk_rise", unstable, 0);
        check_eq("byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check_eq($sformatf("byte%0d_dut%0d", i, s), 32'(g), 32'(exp_q[i]));
        end

        @(negedge clock);
        check_eq("pronto_one_clock", 32'(m_pronto), 32'd0);
        check_eq("back_to_idle", 32'(m_estado), 32'd0);

        idle_bad = 0;
        repeat (20 * div + 10) begin
            @(negedge clock);
            if (m_vsync || m_estado != 4'd0) idle_bad++;
        end
        check_eq($sformatf("no_extra_frame_dut%0d", s), idle_bad, 0);
        ini[s] = 1'b0;
        @(negedge clock);
    endtask

    task automatic reset_mid_line();
        int   cnt, guard;
        logic p;
        sel    = 0;
        ini[0] = 1'b1;
        cnt    = 0;
        guard  = 0;
        p      = m_href;
        while (cnt < 2 && guard < 500) begin
            @(negedge clock);
            guard++;
            if (m_href && !p) cnt++;
            p = m_href;
        end
        check_eq("line1_reached", cnt, 2);
        repeat ($urandom_range(0, 5)) @(negedge clock);
        // A start edge on the reset clock must be ignored.
        reset  = 1'b1;
        ini[0] = 1'b0;
        ini[1] = 1'b1;
        @(negedge clock);
        check_eq("reset_outputs_dut0",
                 {16'd0, vsync0, href0, pclk0, pronto0, d0, est0}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("edge_at_reset_ignored", {27'd0, vsync1, est1}, 32'd0);
        ini[1] = 1'b0;
        @(negedge clock);
        run_frame(0, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sel   = 0;
        reset = 1'b1;
        ini   = 2'b00;
        repeat (3) @(negedge clock);
        check_eq("reset_dut0", {16'd0, vsync0, href0, pclk0, pronto0, d0, est0}, 32'd0);
        check_eq("reset_dut1", {16'd0, vsync1, href1, pclk1, pronto1, d1, est1}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) run_frame(int'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b1);
        run_frame(1, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(1, 1'b1, 1'b0);
        reset_mid_line();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gerador_ov7670.md
# gerador_OV7670

Synthesizable OV7670 camera emulator: drives VSYNC, HREF, PCLK and D[7:0] with the same framing and byte order the capture interface expects. One frame is emitted per start request, with a deterministic RGB565 test pattern. It sits in place of the physical sensor, on the board for bring-up or in the bench facing the capture interface, to close the loop without a camera.

## Interface
- `LINES`, 140: lines per frame
- `COLUMNS`, 320: pixels per line; 2·COLUMNS bytes per line
- `S_LINE`, 8: line counter width
- `S_COLUMN`, 9: column counter width
- `PCLK_DIV`, 2: system clocks per PCLK half-period, ≥1
- `V_PULSE`, 3: VSYNC high width, in PCLK periods
- `V_BACK`, 17: PCLK periods from VSYNC fall to first HREF rise
- `H_BLANK`, 144: PCLK periods HREF low after every line
- `V_FRONT`, 10: PCLK periods after last line's blank before `pronto`

- `clock` in 1: system clock
- `reset` in 1: synchronous, active-high
- `iniciar` in 1: level request, rising edge detected internally
- `VSYNC` out 1: frame sync, active-high
- `HREF` out 1: line valid
- `PCLK` out 1: pixel clock
- `D` out 8: pixel byte
- `pronto` out 1: one-clock pulse at end of frame
- `db_estado` out 4: current state code

## Operation
- `PCLK` free-runs from the first clock after reset. It toggles every `PCLK_DIV` clocks, starts at 0, and has period 2·`PCLK_DIV` clocks.
- `tick` is the clock cycle in which PCLK goes 1→0. `VSYNC`, `HREF`, `D`, state and counters change only on `tick`. Data is therefore stable at every PCLK rising edge.
- Start detection:
  - A rising edge on `iniciar` sets a pending flag, but only in OCIOSO.
  - Edges seen in any other state are discarded.
  - The flag is consumed on the next `tick`.
- States and codes:
  - OCIOSO 0: all outputs low. Leaves on `tick` with the flag set → VSYNC_ATIVO.
  - VSYNC_ATIVO 1: VSYNC=1 for `V_PULSE` periods → PRE.
  - PRE 2: `V_BACK` periods → LINHA.
  - LINHA 3: HREF=1 for 2·`COLUMNS` periods, one byte per period. The high byte of each pixel goes out first, then the low byte. At the end → HBLANK.
  - HBLANK 4: HREF=0, D=0, for `H_BLANK` periods. Then, if this was line `LINES`-1 → POS, otherwise line+1 → LINHA.
  - POS 5: `V_FRONT` periods → FIM.
  - FIM 6: `pronto`=1 for exactly one clock → OCIOSO.
- Counters:
  - Line counter: `S_LINE` bits. Column counter: `S_COLUMN` bits. One byte-phase bit.
  - All are zeroed on entry to VSYNC_ATIVO.
  - Column and phase are zeroed again on entry to each LINHA.
  - A period counter of ≥16 bits is zeroed on every state change.
- `D` is 0 outside LINHA.
- Reset mid-frame: on the next clock, all outputs go to their reset values, state goes to OCIOSO, counters and the pending flag clear, and PCLK restarts its phase.
- A start edge that arrives on the same clock as `reset` is ignored.

## Timing
- Reset values: `PCLK`, `VSYNC`, `HREF`, `pronto` = 0; `D`=8'h00; `db_estado`=4'h0.
- The first VSYNC rise coincides with the first `tick` after the `iniciar` edge. That is at most 2·`PCLK_DIV`+1 clocks after the edge.
- Frame length, first VSYNC tick to `pronto`: (`V_PULSE` + `V_BACK` + `LINES`·(2·`COLUMNS` + `H_BLANK`) + `V_FRONT`) PCLK periods.
- HREF rises and falls on `tick`, together with the first and last byte change.

## Configuration
- `GERADOR_BARRAS_EN` defined: the pattern is 8 vertical RGB565 colour bars. Bar index = column·8/`COLUMNS`. Bars, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Not defined: the pixel value is {line[7:0], column[7:0]}. Upper counter bits are truncated.

## Test plan
- Reset with LINES=2, COLUMNS=4, PCLK_DIV=1, V_PULSE=1, V_BACK=2, H_BLANK=3, V_FRONT=2; macro off.
  - Byte stream: 00,00,00,01,00,02,00,03, then 01,00,01,01,01,02,01,03.
  - HREF high for exactly 8 PCLK periods per line.
  - `pronto` arrives 27 PCLK periods after VSYNC rise.
- Same parameters, macro on, COLUMNS=8: line 0 bytes are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Check every PCLK rising edge during HREF=1: `D` and `HREF` did not change in the preceding clock, for PCLK_DIV=1 and PCLK_DIV=3.
- `iniciar` toggled during LINHA: no second frame. A new edge after `pronto` starts exactly one new frame.
- `reset` asserted mid-line 1: next clock shows all outputs 0 and `db_estado`=0. A later `iniciar` produces a full frame starting at line 0.
- `iniciar` held high continuously: exactly one frame, then the block stays in OCIOSO.
